// File: rtl/muldiv_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | muldiv_pkg : shared encodings for the iterative RV64M mul/div unit    |
// | Revision   : 1.0                                                      |
// +-----------------------------------------------------------------------+
package muldiv_pkg;

    localparam int ITER_DEFAULT = 64;

    // RISC-V funct3 encodings of the supported M-extension ops
    localparam logic [2:0] MD_MUL  = 3'b000;
    localparam logic [2:0] MD_DIV  = 3'b100;
    localparam logic [2:0] MD_DIVU = 3'b101;
    localparam logic [2:0] MD_REM  = 3'b110;
    localparam logic [2:0] MD_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    function automatic logic md_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic md_is_signed(input logic [2:0] op);
        return op[2] & ~op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_datapath.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | muldiv_datapath : shift-add multiply / restoring divide registers     |
// | Revision        : 1.0                                                 |
// +-----------------------------------------------------------------------+
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = ITER_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] ONES    = '1;
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // acc: product accumulator or partial remainder
    // a  : multiplicand or quotient shift register
    // b  : multiplier or divisor
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       op_q, op_d;

    logic [WIDTH-1:0] x_mag, y_mag;
    logic [WIDTH:0]   rem_shift, rem_diff;
    logic             trial_ok;
    logic [WIDTH-1:0] prod_sum;
    logic             y_zero, sgn_ovf, quo_neg;
    logic [WIDTH-1:0] fix_val;

    assign x_mag = (md_is_signed(op) && x[WIDTH-1]) ? -x : x;
    assign y_mag = (md_is_signed(op) && y[WIDTH-1]) ? -y : y;

    // Remainder < divisor holds every step, so bit WIDTH of the difference is the borrow
    assign rem_shift = {acc_q, a_q[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, b_q};
    assign trial_ok  = ~rem_diff[WIDTH];

    assign prod_sum = acc_q + (b_q[0] ? a_q : '0);

    assign y_zero  = (y_q == '0);
    assign sgn_ovf = (x_q == INT_MIN) && (y_q == ONES);
    assign quo_neg = x_q[WIDTH-1] ^ y_q[WIDTH-1];

    always_comb begin
        fix_val = '0;
        case (op_q)
            MD_MUL:  fix_val = acc_q;
            MD_DIV:  fix_val = y_zero ? ONES : sgn_ovf ? x_q : (quo_neg ? -a_q : a_q);
            MD_DIVU: fix_val = y_zero ? ONES : a_q;
            MD_REM:  fix_val = y_zero ? x_q : sgn_ovf ? '0 : (x_q[WIDTH-1] ? -acc_q : acc_q);
            MD_REMU: fix_val = y_zero ? x_q : acc_q;
            default: fix_val = '0;
        endcase
    end

    always_comb begin
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        x_d      = x_q;
        y_d      = y_q;
        op_d     = op_q;
        result_d = result_q;
        if (load) begin
            op_d  = op;
            x_d   = x;
            y_d   = y;
            acc_d = '0;
            a_d   = md_is_div(op) ? x_mag : x;
            b_d   = md_is_div(op) ? y_mag : y;
        end else if (step) begin
            if (md_is_div(op_q)) begin
                acc_d = trial_ok ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                a_d   = {a_q[WIDTH-2:0], trial_ok};
            end else begin
                acc_d = prod_sum;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
            end
        end else if (fix) begin
            result_d = fix_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            x_q      <= x_d;
            y_q      <= y_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | muldiv_unit : fixed-latency iterative RV64M multiply/divide unit      |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = ITER_DEFAULT,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(ITER + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    md_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic             busy_q;
    logic             ready_q;
    logic             accept;

    assign accept = in_valid && ready_q;

    // Outputs are registered alongside the state so they track it exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q <= CALC;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                CALC: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FIX: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    muldiv_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .step   (state_q == CALC),
        .fix    (state_q == FIX),
        .op     (op),
        .x      (x),
        .y      (y),
        .result (result)
    );

    assign in_ready = ready_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_muldiv_unit : directed self-checking bench for muldiv_unit         |
// | Revision       : 1.0                                                  |
// +-----------------------------------------------------------------------+
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int WIDTH = 64;
    // done is seen after the (ITER+1)th edge following the accept edge
    localparam int LAT   = WIDTH + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic [2:0]       op = 3'b000;
    logic [WIDTH-1:0] x = '0;
    logic [WIDTH-1:0] y = '0;
    logic             in_ready;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(
        .WIDTH (WIDTH),
        .ITER  (WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .x        (x),
        .y        (y),
        .result   (result),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output logic [WIDTH-1:0] res, output int lat);
        @(negedge clk);
        op = o; x = a; y = b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!done && lat < 200);
        res = result;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (result !== '0)  begin n_fail++; $display("FAIL reset_result got=%h exp=0", result); end
        n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul;
        logic [WIDTH-1:0] r;
        int l;
        run_op(MD_MUL, 64'd123, 64'd321, r, l);
        n_checks++; if (r !== 64'd39483 || l != LAT) begin n_fail++; $display("FAIL mul_small got=%h lat=%0d exp=%h lat=%0d", r, l, 64'd39483, LAT); end
        run_op(MD_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, r, l);
        n_checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE || l != LAT) begin n_fail++; $display("FAIL mul_wrap got=%h lat=%0d exp=FFFFFFFFFFFFFFFE lat=%0d", r, l, LAT); end
    endtask

    task automatic test_div_signed;
        logic [WIDTH-1:0] r;
        int l;
        run_op(MD_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, r, l);
        n_checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD || l != LAT) begin n_fail++; $display("FAIL div_m7_2 got=%h lat=%0d exp=FFFFFFFFFFFFFFFD", r, l); end
        run_op(MD_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, r, l);
        n_checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF || l != LAT) begin n_fail++; $display("FAIL rem_m7_2 got=%h lat=%0d exp=FFFFFFFFFFFFFFFF", r, l); end
        run_op(MD_DIV, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, r, l);
        n_checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD || l != LAT) begin n_fail++; $display("FAIL div_7_m2 got=%h lat=%0d exp=FFFFFFFFFFFFFFFD", r, l); end
        run_op(MD_REM, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, r, l);
        n_checks++; if (r !== 64'd1 || l != LAT) begin n_fail++; $display("FAIL rem_7_m2 got=%h lat=%0d exp=1", r, l); end
    endtask

    task automatic test_div_unsigned;
        logic [WIDTH-1:0] r;
        int l;
        run_op(MD_DIVU, 64'd12345, 64'd100, r, l);
        n_checks++; if (r !== 64'd123 || l != LAT) begin n_fail++; $display("FAIL divu got=%0d lat=%0d exp=123", r, l); end
        run_op(MD_REMU, 64'd12345, 64'd100, r, l);
        n_checks++; if (r !== 64'd45 || l != LAT) begin n_fail++; $display("FAIL remu got=%0d lat=%0d exp=45", r, l); end
    endtask

    task automatic test_div_zero;
        logic [WIDTH-1:0] r;
        int l;
        run_op(MD_DIV, 64'd42, 64'd0, r, l);
        n_checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF || l != LAT) begin n_fail++; $display("FAIL div_by0 got=%h lat=%0d exp=FFFFFFFFFFFFFFFF", r, l); end
        run_op(MD_REM, 64'd42, 64'd0, r, l);
        n_checks++; if (r !== 64'd42 || l != LAT) begin n_fail++; $display("FAIL rem_by0 got=%h lat=%0d exp=42", r, l); end
        run_op(MD_DIVU, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, r, l);
        n_checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF || l != LAT) begin n_fail++; $display("FAIL divu_by0 got=%h lat=%0d exp=FFFFFFFFFFFFFFFF", r, l); end
        run_op(MD_REMU, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, r, l);
        n_checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFF9 || l != LAT) begin n_fail++; $display("FAIL remu_by0 got=%h lat=%0d exp=FFFFFFFFFFFFFFF9", r, l); end
    endtask

    task automatic test_overflow;
        logic [WIDTH-1:0] r;
        int l;
        run_op(MD_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, l);
        n_checks++; if (r !== 64'h8000_0000_0000_0000 || l != LAT) begin n_fail++; $display("FAIL div_ovf got=%h lat=%0d exp=8000000000000000", r, l); end
        run_op(MD_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, l);
        n_checks++; if (r !== 64'd0 || l != LAT) begin n_fail++; $display("FAIL rem_ovf got=%h lat=%0d exp=0", r, l); end
    endtask

    task automatic test_reserved;
        logic [WIDTH-1:0] r;
        int l;
        run_op(3'b010, 64'd5, 64'd6, r, l);
        n_checks++; if (r !== 64'd0 || l != LAT) begin n_fail++; $display("FAIL reserved_op got=%h lat=%0d exp=0 lat=%0d", r, l, LAT); end
    endtask

    task automatic test_in_flight;
        int l;
        int bad;
        @(negedge clk);
        op = MD_MUL; x = 64'd3; y = 64'd5; in_valid = 1'b1;
        @(posedge clk);
        #1 op = MD_DIV; x = 64'd100; y = 64'd7;
        l = 0;
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1 l++;
            if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL inflight_flags bad_cycles=%0d exp=0", bad); end
        in_valid = 1'b0;
        while (!done && l < 200) begin
            @(posedge clk);
            #1 l++;
        end
        n_checks++; if (result !== 64'd15 || l != LAT) begin n_fail++; $display("FAIL inflight_result got=%0d lat=%0d exp=15 lat=%0d", result, l, LAT); end
        @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL inflight_idle busy=%b in_ready=%b exp busy=0 in_ready=1", busy, in_ready); end
    endtask

    task automatic test_back_to_back;
        logic [WIDTH-1:0] r;
        int l;
        int hold_bad;
        run_op(MD_MUL, 64'd10, 64'd20, r, l);
        n_checks++; if (r !== 64'd200 || in_ready !== 1'b1 || l != LAT) begin n_fail++; $display("FAIL b2b_first got=%0d in_ready=%b lat=%0d exp=200", r, in_ready, l); end
        // Still inside the DONE cycle: issue the next op immediately
        op = MD_DIVU; x = 64'd1000; y = 64'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept done=%b busy=%b exp done=0 busy=1", done, busy); end
        l = 0;
        hold_bad = 0;
        do begin
            @(posedge clk);
            #1 l++;
            if (!done && result !== 64'd200) hold_bad++;
        end while (!done && l < 200);
        n_checks++; if (hold_bad != 0) begin n_fail++; $display("FAIL b2b_hold bad_cycles=%0d exp=0", hold_bad); end
        n_checks++; if (result !== 64'd142 || l != LAT) begin n_fail++; $display("FAIL b2b_second got=%0d lat=%0d exp=142 lat=%0d", result, l, LAT); end
    endtask

    task automatic test_reset_mid_op;
        logic [WIDTH-1:0] r;
        int l;
        logic saw_done;
        @(negedge clk);
        op = MD_MUL; x = 64'h1234_5678; y = 64'h9ABC; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (result !== '0) begin n_fail++; $display("FAIL midrst_result got=%h exp=0", result); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        saw_done = done;
        repeat (3) begin
            @(posedge clk);
            #1 saw_done = saw_done | done;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (70) begin
            @(posedge clk);
            #1 saw_done = saw_done | done;
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done got=%b exp=0", saw_done); end
        run_op(MD_MUL, 64'd6, 64'd7, r, l);
        n_checks++; if (r !== 64'd42 || l != LAT) begin n_fail++; $display("FAIL midrst_after got=%0d lat=%0d exp=42 lat=%0d", r, l, LAT); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div_signed();
        test_div_unsigned();
        test_div_zero();
        test_overflow();
        test_reserved();
        test_in_flight();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
